// File: rtl/pe_broadcast_ctrl.sv
// pe_broadcast_ctrl
//   Per-PE broadcast controller. Scans the local activation register file,
//   sends every selected activation to the router as one data packet, then
//   sends a single finish packet carrying the PE index.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   pe_idx            static PE index
//   start             start pulse, honoured only when idle
//   abort             synchronous abort back to idle (wins over start/send_ready)
//   cfg_act_no        number of valid entries (0..ACT_NO), sampled on start
//   cfg_mode          0 dense, 1 sparse (nonzero), 2 relu (>0), 3 dense; sampled on start
//   act_nz, act_pos   live per-entry nonzero / positive flags
//   rd_en, rd_addr    activation read port (high only while sending data)
//   rd_data           combinational read data for rd_addr
//   send_valid/ready  packet handshake to the router
//   send_data/addr    packet payload and router address (MSB set = finish packet)
//   busy              high whenever not idle
//   done              one-cycle pulse when the finish packet is accepted
//   sent_cnt          data packets accepted in the current/last broadcast
module pe_broadcast_ctrl #(
    parameter int unsigned ACT_NO   = 64,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned PE_IDX_W = 6,
    parameter int unsigned POS_W    = $clog2(ACT_NO),
    parameter int unsigned ADDR_W   = 1 + POS_W + PE_IDX_W + 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PE_IDX_W-1:0] pe_idx,
    input  logic                start,
    input  logic                abort,
    input  logic [POS_W:0]      cfg_act_no,
    input  logic [1:0]          cfg_mode,
    input  logic [ACT_NO-1:0]   act_nz,
    input  logic [ACT_NO-1:0]   act_pos,
    output logic                rd_en,
    output logic [POS_W-1:0]    rd_addr,
    input  logic [DATA_W-1:0]   rd_data,
    output logic                send_valid,
    input  logic                send_ready,
    output logic [DATA_W-1:0]   send_data,
    output logic [ADDR_W-1:0]   send_addr,
    output logic                busy,
    output logic                done,
    output logic [POS_W:0]      sent_cnt
);

    localparam int unsigned CNT_W = POS_W + 1;
    localparam logic [ADDR_W-1:0] FIN_ADDR = {1'b1, {(ADDR_W-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StSend,
        StFinish
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  ptr_q;
    logic [POS_W-1:0]  pos_q;
    logic [CNT_W-1:0]  act_no_q;
    logic [1:0]        mode_q;
    logic [CNT_W-1:0]  sent_cnt_q;

    logic [ACT_NO-1:0] mask;
    logic              lnzd_found;
    logic [POS_W-1:0]  lnzd_pos;

    // Selection mask follows the live flags; only the mode itself is latched.
    always_comb begin
        unique case (mode_q)
            2'd1:    mask = act_nz;
            2'd2:    mask = act_pos;
            default: mask = '1;
        endcase
    end

    // Lowest selected entry in [ptr_q, act_no_q). Scanning downwards lets the
    // lowest hit overwrite the others. ptr_q has one extra bit so stepping past
    // the last entry never wraps back to 0.
    always_comb begin
        lnzd_found = 1'b0;
        lnzd_pos   = '0;
        for (int i = ACT_NO - 1; i >= 0; i--) begin
            if (mask[i] && (CNT_W'(i) >= ptr_q) && (CNT_W'(i) < act_no_q)) begin
                lnzd_found = 1'b1;
                lnzd_pos   = POS_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            pos_q      <= '0;
            act_no_q   <= '0;
            mode_q     <= '0;
            sent_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        act_no_q   <= cfg_act_no;
                        mode_q     <= cfg_mode;
                        ptr_q      <= '0;
                        sent_cnt_q <= '0;
                        state_q    <= StScan;
                    end
                end
                StScan: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else begin
                        pos_q   <= lnzd_pos;
                        state_q <= lnzd_found ? StSend : StFinish;
                    end
                end
                StSend: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else if (send_ready) begin
                        ptr_q      <= CNT_W'(pos_q) + CNT_W'(1);
                        sent_cnt_q <= sent_cnt_q + CNT_W'(1);
                        state_q    <= StScan;
                    end
                end
                StFinish: begin
                    if (abort || send_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs decode straight from registered state, so they are stable for
    // the whole of a stalled send and drop as soon as reset is asserted.
    always_comb begin
        rd_en      = 1'b0;
        rd_addr    = '0;
        send_valid = 1'b0;
        send_data  = '0;
        send_addr  = '0;
        done       = 1'b0;
        unique case (state_q)
            StSend: begin
                rd_en      = 1'b1;
                rd_addr    = pos_q;
                send_valid = 1'b1;
                send_data  = rd_data;
                send_addr  = ADDR_W'({pos_q, pe_idx});
            end
            StFinish: begin
                send_valid = 1'b1;
                send_data  = DATA_W'(pe_idx);
                send_addr  = FIN_ADDR;
                done       = send_ready && !abort;
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign sent_cnt = sent_cnt_q;

endmodule
